seg_display: RTL and testbench

Memory-mapped four-digit seven-segment display controller on the peripheral bus. It holds a hex value, per-digit enable/dot bits and optional raw segment patterns, all written by the CPU through the peripheral port. A refresh counter time-multiplexes the four digits onto the shared segment and anode pins. It sits behind the peripheral address decoder, which supplies a local offset and a select strobe.

---
 rtl/seg_display.sv | 148 ++++++++++++++
 tb/tb_seg_display.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_display.sv
// Four-digit seven-segment display controller on the peripheral bus.
// Ports: clk/rst, bus A/WD/WE/sel -> RD, pins hex/hex_dot/hex_sel.
module seg_display #(
    parameter int REFRESH_DIV = 50000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  A,
    input  logic [31:0] WD,
    input  logic        WE,
    input  logic        sel,
    output logic [31:0] RD,
    output logic [6:0]  hex,
    output logic        hex_dot,
    output logic [3:0]  hex_sel
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [1:0]    dig_q;
    logic [15:0]   value_q;
    logic [8:0]    ctrl_q;
    logic [27:0]   raw_q;

    logic          wr_en;
    logic          wrap;
    logic [3:0]    nib;
    logic [6:0]    raw_seg;
    logic [6:0]    glyph;
    logic [6:0]    seg_n;
    logic          dot_n;
    logic [3:0]    an_n;

    // Address/data bits the register map never looks at.
    logic unused_bus;
    assign unused_bus = ^{A[4], A[1:0], WD[31:28]};

    assign wr_en = sel & WE;
    assign wrap  = (cnt_q == CNT_LAST);

    // Active-high glyph for one hex nibble, segments {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0:    g = 7'h3F;
            4'h1:    g = 7'h06;
            4'h2:    g = 7'h5B;
            4'h3:    g = 7'h4F;
            4'h4:    g = 7'h66;
            4'h5:    g = 7'h6D;
            4'h6:    g = 7'h7D;
            4'h7:    g = 7'h07;
            4'h8:    g = 7'h7F;
            4'h9:    g = 7'h6F;
            4'hA:    g = 7'h77;
            4'hB:    g = 7'h7C;
            4'hC:    g = 7'h39;
            4'hD:    g = 7'h5E;
            4'hE:    g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction

    always_comb begin
        nib     = value_q[3:0];
        raw_seg = raw_q[6:0];
        case (dig_q)
            2'd1: begin
                nib     = value_q[7:4];
                raw_seg = raw_q[13:7];
            end
            2'd2: begin
                nib     = value_q[11:8];
                raw_seg = raw_q[20:14];
            end
            2'd3: begin
                nib     = value_q[15:12];
                raw_seg = raw_q[27:21];
            end
            default: ;
        endcase
    end

    assign glyph = ctrl_q[8] ? raw_seg : hex_glyph(nib);

    // Logical (active-high) pin values for the digit being scanned.
    always_comb begin
        seg_n = 7'h00;
        dot_n = 1'b0;
        an_n  = 4'h0;
        if (ctrl_q[dig_q]) begin
            seg_n = glyph;
            dot_n = ctrl_q[3'd4 + {1'b0, dig_q}];
            an_n  = 4'b0001 << dig_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            dig_q   <= 2'd0;
            value_q <= 16'h0000;
            ctrl_q  <= 9'h00F;
            raw_q   <= 28'h0;
        end else begin
            cnt_q <= wrap ? '0 : cnt_q + 1'b1;
            if (wrap) dig_q <= dig_q + 2'd1;
            if (wr_en) begin
                case (A[3:2])
                    2'd0:    value_q <= WD[15:0];
                    2'd1:    ctrl_q  <= WD[8:0];
                    2'd2:    raw_q   <= WD[27:0];
                    default: ;
                endcase
            end
        end
    end

    // Polarity is folded in ahead of the pin registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hex     <= {7{ACTIVE_LOW}};
            hex_dot <= ACTIVE_LOW;
            hex_sel <= {4{ACTIVE_LOW}};
        end else begin
            hex     <= seg_n ^ {7{ACTIVE_LOW}};
            hex_dot <= dot_n ^ ACTIVE_LOW;
            hex_sel <= an_n ^ {4{ACTIVE_LOW}};
        end
    end

    always_comb begin
        RD = 32'h0;
        if (sel) begin
            case (A[3:2])
                2'd0:    RD = {16'h0, value_q};
                2'd1:    RD = {23'h0, ctrl_q};
                2'd2:    RD = {4'h0, raw_q};
                default: RD = {30'h0, dig_q};
            endcase
        end
    end

endmodule

// File: tb/tb_seg_display.sv
// Testbench for seg_display: directed bus traffic, behavioural pin model.
// Ports exercised: all bus inputs, RD and the three pin outputs.
module tb_seg_display;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  A   = 5'h0;
    logic [31:0] WD  = 32'h0;
    logic        WE  = 1'b0;
    logic        sel = 1'b0;
    logic [31:0] RD;
    logic [6:0]  hex;
    logic        hex_dot;
    logic [3:0]  hex_sel;

    always #5 clk = ~clk;

    seg_display #(.REFRESH_DIV(DIV), .ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst(rst), .A(A), .WD(WD), .WE(WE), .sel(sel),
        .RD(RD), .hex(hex), .hex_dot(hex_dot), .hex_sel(hex_sel)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
        end
    endtask

    // Glyphs written as the list of lit segment letters.
    string GLYPH [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                          "acdefg", "abc", "abcdefg", "abcdfg", "abcefg",
                          "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    function automatic logic [6:0] lit(input logic [3:0] n);
        logic [6:0] r;
        string s;
        r = 7'h0;
        s = GLYPH[n];
        for (int i = 0; i < s.len(); i++) r[int'(s.getc(i)) - 97] = 1'b1;
        return r;
    endfunction

    // Model: k counts non-reset edges since reset; digit = (k/DIV) mod 4.
    int          k = 0;
    logic [15:0] m_val;
    logic [8:0]  m_ctrl;
    logic [27:0] m_raw;
    logic [6:0]  e_hex;
    logic        e_dot;
    logic [3:0]  e_sel;
    bit          live = 0;
    int          md;
    logic [6:0]  ms;

    always @(posedge clk) begin
        if (rst) begin
            k = 0; m_val = 16'h0; m_ctrl = 9'h00F; m_raw = 28'h0;
            e_hex = 7'h7F; e_dot = 1'b1; e_sel = 4'hF;
        end else begin
            md = (k / DIV) % 4;
            if (m_ctrl[md]) begin
                ms = m_ctrl[8] ? m_raw[7*md +: 7] : lit(m_val[4*md +: 4]);
                e_hex = ~ms;
                e_dot = ~m_ctrl[4+md];
                e_sel = ~(4'b0001 << md);
            end else begin
                e_hex = 7'h7F; e_dot = 1'b1; e_sel = 4'hF;
            end
            k++;
            if (sel && WE) begin
                case (A[3:2])
                    2'd0: m_val  = WD[15:0];
                    2'd1: m_ctrl = WD[8:0];
                    2'd2: m_raw  = WD[27:0];
                    default: ;
                endcase
            end
        end
        live = 1;
    end

    always @(negedge clk) begin
        if (live) begin
            chk("pin_hex", {25'h0, hex}, {25'h0, e_hex});
            chk("pin_dot", {31'h0, hex_dot}, {31'h0, e_dot});
            chk("pin_sel", {28'h0, hex_sel}, {28'h0, e_sel});
        end
    end

    // Called right after a negedge; returns on the negedge after the write edge.
    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        sel = 1'b1; WE = 1'b1; A = a; WD = d;
        @(negedge clk);
        sel = 1'b0; WE = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [4:0] a,
                          input logic [31:0] exp);
        sel = 1'b1; A = a;
        #1;
        chk(name, RD, exp);
        sel = 1'b0;
    endtask

    function automatic logic [6:0] g1234(input logic [3:0] s);
        case (s)
            4'hE:    return 7'h19;
            4'hD:    return 7'h30;
            4'hB:    return 7'h24;
            4'h7:    return 7'h79;
            default: return 7'h7F;
        endcase
    endfunction

    int cnt_e, cnt_d, cnt_b, cnt_7, cnt_f;

    initial begin
        // 1. reset
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_hex", {25'h0, hex}, 32'h7F);
        chk("rst_dot", {31'h0, hex_dot}, 32'h1);
        chk("rst_sel", {28'h0, hex_sel}, 32'hF);
        rst = 1'b0;
        @(negedge clk);
        chk("first_sel", {28'h0, hex_sel}, 32'hE);
        chk("first_hex", {25'h0, hex}, 32'h40);
        rd_chk("rd_ctrl_rst", 5'h04, 32'h00F);
        rd_chk("rd_status_rst", 5'h0C, 32'h0);

        // 2. value 0x1234, full frame
        wr(5'h00, 32'h1234);
        @(negedge clk);
        cnt_e = 0; cnt_d = 0; cnt_b = 0; cnt_7 = 0;
        for (int i = 0; i < 16; i++) begin
            chk("v1234_hex", {25'h0, hex}, {25'h0, g1234(hex_sel)});
            cnt_e += (hex_sel == 4'hE); cnt_d += (hex_sel == 4'hD);
            cnt_b += (hex_sel == 4'hB); cnt_7 += (hex_sel == 4'h7);
            @(negedge clk);
        end
        chk("hold_d0", cnt_e, 4); chk("hold_d1", cnt_d, 4);
        chk("hold_d2", cnt_b, 4); chk("hold_d3", cnt_7, 4);

        // 3. digits 0,2 enabled, dot on digit 1 (disabled)
        wr(5'h04, 32'h0025);
        @(negedge clk);
        cnt_f = 0;
        for (int i = 0; i < 16; i++) begin
            chk("c25_dot", {31'h0, hex_dot}, 32'h1);
            if (hex_sel == 4'hF) begin
                cnt_f++;
                chk("c25_blank", {25'h0, hex}, 32'h7F);
            end else begin
                chk("c25_hex", {25'h0, hex}, {25'h0, g1234(hex_sel)});
            end
            @(negedge clk);
        end
        chk("c25_blank_slots", cnt_f, 8);

        wr(5'h04, 32'h001F);
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            chk("dot0", {31'h0, hex_dot}, (hex_sel == 4'hE) ? 32'h0 : 32'h1);
            @(negedge clk);
        end

        // 4. raw mode
        wr(5'h08, 32'h0000007F);
        wr(5'h04, 32'h0000010F);
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            chk("raw_hex", {25'h0, hex}, (hex_sel == 4'hE) ? 32'h00 : 32'h7F);
            @(negedge clk);
        end
        wr(5'h04, 32'h0000000F);
        @(negedge clk);
        chk("raw_off_hex", {25'h0, hex}, {25'h0, g1234(hex_sel)});

        // 5. bus checks
        sel = 1'b0; WE = 1'b1; A = 5'h00; WD = 32'hDEAD;
        @(negedge clk);
        WE = 1'b0;
        rd_chk("nosel_write", 5'h00, 32'h1234);
        A = 5'h00; sel = 1'b0; #1;
        chk("rd_nosel", RD, 32'h0);
        wr(5'h0C, 32'h3);
        rd_chk("status_wr_val", 5'h00, 32'h1234);
        rd_chk("status_rd", 5'h0C, 32'((k / DIV) % 4));
        wr(5'h00, 32'hFFFFABCD);
        rd_chk("value_mask", 5'h00, 32'h0000ABCD);
        rd_chk("addr_alias", 5'h13, 32'h0000ABCD);
        wr(5'h04, 32'hFFFFFFFF);
        rd_chk("ctrl_mask", 5'h04, 32'h000001FF);
        wr(5'h08, 32'hFFFFFFFF);
        rd_chk("raw_mask", 5'h08, 32'h0FFFFFFF);
        wr(5'h04, 32'h0000000F);
        wr(5'h08, 32'h0);
        repeat (16) @(negedge clk);

        // 6. reset at d=2, cnt=3 with a write pending
        begin
            int budget;
            budget = 0;
            while ((k % 16) != 11 && budget < 64) begin
                @(negedge clk);
                budget++;
            end
            chk("wait_d2c3", budget < 64, 1);
        end
        rst = 1'b1; sel = 1'b1; WE = 1'b1; A = 5'h00; WD = 32'h5555;
        @(negedge clk);
        rst = 1'b0; sel = 1'b0; WE = 1'b0;
        rd_chk("mid_rst_val", 5'h00, 32'h0);
        rd_chk("mid_rst_status", 5'h0C, 32'h0);
        chk("mid_rst_sel", {28'h0, hex_sel}, 32'hF);
        @(negedge clk);
        chk("post_rst_sel", {28'h0, hex_sel}, 32'hE);
        chk("post_rst_hex", {25'h0, hex}, 32'h40);
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
